// File: rtl/q_meas_scheduler.sv
// Round-robin charge-measurement sequencer: walks the enabled channels, pulses one
// meas_start at a time, captures each result or times it out, and hands it off over a valid/ready port.
module q_meas_scheduler #(
    parameter int N_CH      = 4,
    parameter int WIDTH     = 10,
    parameter int TMO_WIDTH = 8,
    parameter int SETTLE    = 2,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_CH-1:0]         ch_mask,
    output logic [N_CH-1:0]         meas_start,
    input  logic [N_CH-1:0]         meas_ready,
    input  logic [N_CH*WIDTH-1:0]   meas_q,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CH_W-1:0]         res_ch,
    output logic [WIDTH-1:0]        res_q,
    output logic                    res_timeout,
    output logic                    busy,
    output logic                    scan_done
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE - 32'sd1);
    // Last count value before the timeout fires, so MEASURE lasts 2**TMO_WIDTH-1 cycles.
    localparam logic [TMO_WIDTH-1:0] TMO_LAST    = ~TMO_WIDTH'(1'b1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        CLEAR   = 3'd2,
        MEASURE = 3'd3,
        CAPTURE = 3'd4,
        OUTPUT  = 3'd5
    } state_t;

    state_t                state_r;
    logic [CH_W-1:0]       idx_r;
    logic [N_CH-1:0]       scan_mask_r;
    logic [SET_W-1:0]      settle_r;
    logic [TMO_WIDTH-1:0]  tmo_r;

    logic [WIDTH-1:0]      q_arr_s [N_CH];
    logic [WIDTH-1:0]      q_sel_s;
    logic [CH_W-1:0]       first_idx_s;
    logic                  more_s;
    logic [N_CH-1:0]       start_oh_s;

    function automatic logic [CH_W-1:0] first_at_or_above(input logic [N_CH-1:0] mask,
                                                          input logic [CH_W-1:0] from);
        logic [CH_W-1:0] sel;
        sel = from;
        for (int i = N_CH - 1; i >= 0; i--) begin
            sel = (mask[i] && (i >= int'(from))) ? CH_W'(i) : sel;
        end
        return sel;
    endfunction

    function automatic logic any_above(input logic [N_CH-1:0] mask,
                                       input logic [CH_W-1:0] from);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            hit = hit | (mask[i] && (i > int'(from)));
        end
        return hit;
    endfunction

    for (genvar g = 0; g < N_CH; g++) begin : g_q_slice
        assign q_arr_s[g] = meas_q[g*WIDTH +: WIDTH];
    end

    // Channel selection helpers derived from the latched scan mask and current index.
    always_comb begin
        q_sel_s     = q_arr_s[idx_r];
        first_idx_s = first_at_or_above(scan_mask_r, idx_r);
        more_s      = any_above(scan_mask_r, idx_r);
        start_oh_s  = N_CH'(1'b1) << idx_r;
    end

    // Scan FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            scan_mask_r <= '0;
            settle_r    <= '0;
            tmo_r       <= '0;
            meas_start  <= '0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_q       <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (en && (ch_mask != '0)) begin
                        scan_mask_r <= ch_mask;
                        idx_r       <= '0;
                        busy        <= 1'b1;
                        state_r     <= SELECT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SELECT: begin
                    idx_r    <= first_idx_s;
                    settle_r <= '0;
                    state_r  <= CLEAR;
                end
                CLEAR: begin
                    if (settle_r == SETTLE_LAST) begin
                        meas_start <= start_oh_s;
                        tmo_r      <= '0;
                        state_r    <= MEASURE;
                    end else begin
                        settle_r <= settle_r + SET_W'(1'b1);
                    end
                end
                MEASURE: begin
                    tmo_r <= tmo_r + TMO_WIDTH'(1'b1);
                    // Ready wins over a timeout landing on the same cycle.
                    if (meas_ready[idx_r]) begin
                        state_r <= CAPTURE;
                    end else if (tmo_r == TMO_LAST) begin
                        meas_start  <= '0;
                        res_q       <= '0;
                        res_timeout <= 1'b1;
                        res_ch      <= idx_r;
                        res_valid   <= 1'b1;
                        state_r     <= OUTPUT;
                    end else begin
                        state_r <= MEASURE;
                    end
                end
                CAPTURE: begin
                    meas_start  <= '0;
                    res_q       <= q_sel_s;
                    res_timeout <= 1'b0;
                    res_ch      <= idx_r;
                    res_valid   <= 1'b1;
                    state_r     <= OUTPUT;
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (more_s && en) begin
                            idx_r   <= idx_r + CH_W'(1'b1);
                            state_r <= SELECT;
                        end else if (more_s) begin
                            busy    <= 1'b0;
                            state_r <= IDLE;
                        end else begin
                            scan_done <= 1'b1;
                            if (en && (ch_mask != '0)) begin
                                scan_mask_r <= ch_mask;
                                idx_r       <= '0;
                                state_r     <= SELECT;
                            end else begin
                                busy    <= 1'b0;
                                state_r <= IDLE;
                            end
                        end
                    end else begin
                        state_r <= OUTPUT;
                    end
                end
                default: begin
                    meas_start <= '0;
                    res_valid  <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/q_meas_scheduler.md
Q_MEAS_SCHEDULER -- requirements
Module: q_meas_scheduler

Interface
REQ-001 Parameter N_CH, default 4: number of charge-measurement channels sequenced (2..16).
REQ-002 Parameter WIDTH, default 10: width of each channel's measured_q bus and of res_q.
REQ-003 Parameter TMO_WIDTH, default 8: width of the per-channel timeout counter.
REQ-004 Parameter SETTLE, default 2: cycles start is held low before a measurement (discharge/clear time, >=1).
REQ-005 Derived CH_W = clog2(N_CH), minimum 1.
REQ-006 Port clk, input, 1: single clock, all state on posedge clk.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port en, input, 1: scan enable; scans repeat while high.
REQ-009 Port ch_mask, input, N_CH: bit i=1 includes channel i in a scan.
REQ-010 Port meas_start, output, N_CH: per-channel start to measurement units; at most one bit high.
REQ-011 Port meas_ready, input, N_CH: per-channel ready from measurement units.
REQ-012 Port meas_q, input, N_CH*WIDTH: channel i value at bits [i*WIDTH +: WIDTH].
REQ-013 Port res_valid, output, 1 / res_ready, input, 1: result handshake; transfer when both high on a clk edge.
REQ-014 Port res_ch, output, CH_W / res_q, output, WIDTH / res_timeout, output, 1: result channel, value, timeout flag.
REQ-015 Port busy, output, 1: high in any state other than IDLE.
REQ-016 Port scan_done, output, 1: one-cycle pulse after the last enabled channel's result is accepted.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, CLEAR, MEASURE, CAPTURE, OUTPUT.
REQ-018 IDLE: if en=1 and ch_mask!=0, latch ch_mask into scan_mask, set index to 0, go to SELECT; otherwise stay in IDLE with busy=0.
REQ-019 SELECT: advance index to the lowest set bit of scan_mask at or above the current index, then go to CLEAR; channels with mask bit 0 are skipped at zero extra cycles per skipped channel.
REQ-020 CLEAR: meas_start all 0 for exactly SETTLE cycles, then go to MEASURE.
REQ-021 MEASURE: meas_start[index]=1, timeout counter counts up from 0 each cycle.
REQ-022 MEASURE: on meas_ready[index]=1, go to CAPTURE.
REQ-023 MEASURE: if the counter reaches 2**TMO_WIDTH-1 with no ready, go to OUTPUT with res_q=0 and res_timeout=1.
REQ-024 Ready has priority over timeout when both occur on the same cycle.
REQ-025 CAPTURE lasts exactly one cycle with meas_start[index] still high, because measured_q is registered one cycle after ready.
REQ-026 CAPTURE: register meas_q slice[index] into res_q and set res_timeout=0.
REQ-027 OUTPUT: meas_start all 0, res_valid=1, res_ch=index, and res_ch, res_q and res_timeout held stable until res_ready=1.
REQ-028 On handshake: res_valid drops the next cycle.
REQ-029 On handshake, if more enabled channels remain above index, go to SELECT.
REQ-030 On handshake, if none remain, pulse scan_done, then go to SELECT at index 0 if en=1 and ch_mask!=0 (re-latching ch_mask), else go to IDLE.
REQ-031 ch_mask changes mid-scan SHALL NOT affect the current scan.
REQ-032 en deassertion mid-scan SHALL complete the current channel through its handshake, then go to IDLE without scan_done.
REQ-033 res_ready high outside OUTPUT is ignored; meas_ready on non-selected channels is ignored.
REQ-034 Channel-to-result latency for an immediate ready is SETTLE + 1 (MEASURE) + 1 (CAPTURE) cycles after SELECT, then res_valid.

Reset
REQ-035 rst_n=0 SHALL immediately set: state IDLE, meas_start=0, res_valid=0, res_q=0, res_ch=0, res_timeout=0, busy=0, scan_done=0, counters and scan_mask cleared.
REQ-036 Reset mid-measurement SHALL drop meas_start asynchronously; no partial result is emitted after release.
REQ-037 After rst_n rises, the first scan starts no earlier than the first clk edge with en=1.

Verification
REQ-038 ch_mask=4'b1111, each channel readies 5 cycles into MEASURE with q=30*i, res_ready=1 -> four results ch 0..3, res_q 0,30,60,90, res_timeout=0, then one scan_done pulse.
REQ-039 ch_mask=4'b0101 -> results only for ch 0 and 2; meas_start[1] and meas_start[3] never high.
REQ-040 Channel 1 never readies, TMO_WIDTH=4 -> ch 1 result after 15 MEASURE cycles with res_q=0, res_timeout=1; scan continues to ch 2.
REQ-041 res_ready held low for 10 cycles in OUTPUT -> res_valid, res_ch and res_q stable all 10 cycles; meas_start all 0.
REQ-042 en dropped during ch 1 MEASURE -> ch 1 result delivered, then IDLE, busy=0, no scan_done.
REQ-043 rst_n pulsed low during MEASURE -> meas_start=0 within the same cycle, all outputs at reset values, no result after release.
